// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // ADDI x0,x0,0

  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_KILL,
    S_FULL
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry buffer that parks a fetched {instr, pc} while ID is stalled.
module if_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc_in,
  output logic         full,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc
);

  logic         full_q;
  logic [W-1:0] instr_q;
  logic [W-1:0] pc_q;

  // Occupancy flag: clear wins over load so a flush always empties the entry.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)        full_q <= 1'b0;
    else if (clear) full_q <= 1'b0;
    else if (load)  full_q <= 1'b1;
  end

  // Payload storage, written only on load.
  // NOTE: payload is not reset; it is never observed unless full_q is set.
  always_ff @(posedge clk) begin
    if (load) begin
      instr_q <= instr_in;
      pc_q    <= pc_in;
    end
  end

  assign full  = full_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, skid buffer and redirect kill.
module if_stage
  import if_pkg::*;
#(
  parameter int              DATA_W    = XLEN,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              im_req,
  output logic [DATA_W-1:0] im_addr,
  input  logic              im_ready,
  input  logic [DATA_W-1:0] im_rdata,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc,
  output logic              if_id_valid
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] redir_q, redir_d;

  logic              deliver;
  logic [DATA_W-1:0] deliver_instr;
  logic [DATA_W-1:0] deliver_pc;
  logic              skid_load, skid_clear, skid_full;
  logic [DATA_W-1:0] skid_instr, skid_pc;

  if_skid_buf #(.W(DATA_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .instr_in (im_rdata),
    .pc_in    (req_addr_q),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  // State, fetch address and pending redirect target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_addr_q <= RESET_PC;
      redir_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      redir_q    <= redir_d;
    end
  end

  // Next-state, next-address and delivery decisions.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    redir_d       = redir_q;
    deliver       = 1'b0;
    deliver_instr = im_rdata;
    deliver_pc    = req_addr_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (flush) begin
          if (im_ready) begin
            req_addr_d = redirect_pc;        // returning word is dropped
          end else begin
            redir_d = redirect_pc;           // address must hold until ready
            state_d = S_KILL;
          end
        end else if (im_ready) begin
          req_addr_d = req_addr_q + DATA_W'(PC_STEP);
          if (stall) begin
            skid_load = 1'b1;
            state_d   = S_FULL;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      S_KILL: begin
        if (flush) redir_d = redirect_pc;
        if (im_ready) begin
          req_addr_d = flush ? redirect_pc : redir_q;
          state_d    = S_REQ;
        end
      end
      S_FULL: begin
        if (flush) begin
          skid_clear = 1'b1;
          req_addr_d = redirect_pc;
          state_d    = S_REQ;
        end else if (!stall && skid_full) begin
          skid_clear    = 1'b1;
          deliver       = 1'b1;
          deliver_instr = skid_instr;
          deliver_pc    = skid_pc;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID pipeline register: flush beats stall, otherwise load word or bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else if (flush) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (deliver) begin
        if_id_instr <= deliver_instr;
        if_id_pc    <= deliver_pc;
        if_id_valid <= 1'b1;
      end else begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end

  assign im_addr = req_addr_q;
  assign im_req  = (state_q == S_REQ) || (state_q == S_KILL);

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios then randomized traffic
// compared against a queue-based behavioural model of the fetch stream.
module tb_if_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready = 1'b1;
  logic [31:0] im_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  int vectors = 0;
  int miscompares = 0;

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ready    (im_ready),
    .im_rdata    (im_rdata),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0 holds 32'h00500093, all others a hashed value.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0050_0093;
  endfunction

  assign im_rdata = word_at(im_addr);

  // Reference model: fetch stream with an optional doomed request and a held queue.
  bit          m_started;
  logic [31:0] m_addr;
  bit          m_doomed;
  logic [31:0] m_target;
  if_id_t      m_held[$];
  if_id_t      m_out;

  task automatic model_reset();
    m_started = 1'b0;
    m_addr    = 32'h0;
    m_doomed  = 1'b0;
    m_target  = 32'h0;
    m_held.delete();
    m_out     = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0};
  endtask

  task automatic model_step(input bit r, input bit s, input bit f,
                            input logic [31:0] rpc, input bit rdy);
    if_id_t got;
    bit     have;
    have = 1'b0;
    got  = '0;
    if (r) begin
      model_reset();
      return;
    end
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_held.size() != 0) begin
      if (f) begin
        m_held.delete();
        m_addr = rpc;
      end else if (!s) begin
        got  = m_held.pop_front();
        have = 1'b1;
      end
    end else if (rdy) begin
      if (m_doomed || f) begin
        m_addr   = f ? rpc : m_target;
        m_doomed = 1'b0;
      end else begin
        got    = '{instr: word_at(m_addr), pc: m_addr, valid: 1'b1};
        m_addr = m_addr + 32'd4;
        if (s) m_held.push_back(got);
        else   have = 1'b1;
      end
    end else if (f) begin
      m_doomed = 1'b1;
      m_target = rpc;
    end
    if (f) begin
      m_out.instr = NOP_INSTR;
      m_out.valid = 1'b0;
    end else if (!s) begin
      if (have) begin
        m_out = got;
      end else begin
        m_out.instr = NOP_INSTR;
        m_out.valid = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit req_exp;
    req_exp = m_started && (m_held.size() == 0);
    check("im_req", {31'b0, im_req}, {31'b0, req_exp});
    if (req_exp) check("im_addr", im_addr, m_addr);
    check("if_id_instr", if_id_instr, m_out.instr);
    check("if_id_pc", if_id_pc, m_out.pc);
    check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_out.valid});
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cyc(input bit r, input bit s, input bit f,
                     input logic [31:0] rpc, input bit rdy);
    rst = r; stall = s; flush = f; redirect_pc = rpc; im_ready = rdy;
    @(posedge clk);
    model_step(r, s, f, rpc, rdy);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] rpc;
    bit          r, s, f, rdy;
    model_reset();

    // Reset and startup
    cyc(1, 0, 0, 32'h0, 1);
    cyc(1, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);                 // first request at 0
    check("boot_addr", im_addr, 32'h0);
    cyc(0, 0, 0, 32'h0, 1);                 // word 0 delivered
    check("boot_instr", if_id_instr, 32'h0050_0093);
    cyc(0, 0, 0, 32'h0, 1);                 // word 4, request 8

    // Slow memory on 0x8
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    check("slow_hold_addr", im_addr, 32'h8);
    cyc(0, 0, 0, 32'h0, 1);                 // 0x8 captured

    // Stall with skid while 0xC returns
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 1, 0, 32'h0, 1);
    check("full_no_req", {31'b0, im_req}, 32'h0);
    cyc(0, 0, 0, 32'h0, 1);                 // 0xC from skid
    cyc(0, 0, 0, 32'h0, 1);                 // 0x10 fetched

    // Flush while 0x14 is outstanding
    cyc(0, 0, 1, 32'h100, 0);
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 1);                 // 0x14 discarded
    check("kill_addr", im_addr, 32'h100);
    cyc(0, 0, 0, 32'h0, 1);                 // 0x100 delivered

    // Flush and stall together while the skid is full
    cyc(0, 1, 0, 32'h0, 1);
    cyc(0, 1, 1, 32'h40, 1);
    cyc(0, 0, 0, 32'h0, 1);                 // 0x40 delivered
    check("flush_full_pc", if_id_pc, 32'h40);

    // Address wrap
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1);
    cyc(0, 0, 0, 32'h0, 1);
    check("wrap_addr", im_addr, 32'h0);

    // Reset during a killed request
    cyc(0, 0, 1, 32'h200, 0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 1);
    cyc(0, 0, 0, 32'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 3) == 0);
      f   = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : $urandom();
      rpc[1:0] = 2'b00;
      cyc(r, s, f, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the instruction decoder/controller.
- Owns the fetch address register and issues requests to instruction memory over a req/ready handshake.
- Presents one instruction word and its PC per cycle to the ID stage.
- Handles ID stalls with a one-entry skid buffer. Handles branch/jump redirects by flushing to a NOP bubble and discarding any in-flight fetch.

Parameters:
- DATA_W, 32: instruction and address width; equals `data_size.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding, ADDI x0,x0,0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  ID stage cannot accept; IF/ID must hold.
- flush  in  1  redirect request from branch/jump resolution.
- redirect_pc  in  DATA_W  target address, valid when flush=1.
- im_req  out  1  instruction memory request.
- im_addr  out  DATA_W  request address; stable while im_req=1 and im_ready=0.
- im_ready  in  1  memory returns im_rdata this cycle; request completes.
- im_rdata  in  DATA_W  fetched word.
- if_id_instr  out  DATA_W  instruction to decoder.
- if_id_pc  out  DATA_W  PC of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real instruction.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-high.
  - All state updates on rising clk.
  - rst overrides all other inputs, including mid-request.
- Reset values:
  - state=S_IDLE, req_addr_q=RESET_PC, im_req=0.
  - if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0.
  - Skid buffer empty.
- Outputs:
  - im_addr=req_addr_q at all times.
  - im_req=1 exactly in S_REQ and S_KILL.
- FSM states: S_IDLE, S_REQ, S_KILL, S_FULL.
- S_IDLE: next cycle goes to S_REQ. Latency: first im_req is the cycle after rst deasserts.
- S_REQ, flush=1:
  - im_ready=1: drop word, req_addr_q<=redirect_pc, stay S_REQ.
  - im_ready=0: redir_q<=redirect_pc, go to S_KILL. im_addr must not change mid-request.
- S_REQ, flush=0, im_ready=1:
  - stall=0: IF/ID<={im_rdata, req_addr_q, valid=1}, req_addr_q<=req_addr_q+4, stay S_REQ.
  - stall=1: skid<={im_rdata, req_addr_q}, req_addr_q<=req_addr_q+4, go to S_FULL.
- S_REQ, flush=0, im_ready=0: hold.
- S_KILL:
  - Keeps requesting the old address.
  - A further flush overwrites redir_q.
  - On im_ready: discard word, req_addr_q<=redir_q (or redirect_pc if flush that same cycle), go to S_REQ.
- S_FULL:
  - No request issued.
  - flush: skid emptied, req_addr_q<=redirect_pc, go to S_REQ.
  - Else stall=0: IF/ID<=skid with valid=1, go to S_REQ.
  - Else hold.
- IF/ID register priority:
  - flush: {NOP_INSTR, valid=0}; if_id_pc unchanged. Flush beats stall.
  - Else stall: hold all three outputs.
  - Else load: delivered word (from memory or skid) with valid=1, or a bubble {NOP_INSTR, valid=0} if nothing delivered.
- Throughput and latency:
  - With im_ready tied high and no stall/flush: one instruction per cycle.
  - Fetch-to-IF/ID latency is 1 cycle.
- Arithmetic: PC increment is +4, unsigned, wrapping mod 2^DATA_W (32'hFFFF_FFFC -> 0).
- Alignment: redirect_pc is used as given; alignment checking is the downstream stage's responsibility.
- Invariants:
  - At most one memory request outstanding.
  - A word arriving in S_KILL never reaches IF/ID.
  - At most one instruction is held in skid plus IF/ID beyond the consumed stream; no instruction is duplicated or lost.

Decomposition:
- Shared package (if_pkg), holding:
  - fetch_state_e enum {S_IDLE, S_REQ, S_KILL, S_FULL}.
  - NOP_INSTR constant.
  - PC_STEP=4.
  - if_id_t struct {instr, pc, valid}.
- A natural sub-module is if_skid_buf: one-entry buffer holding {instr, pc} with load/clear/full. Everything else stays in if_stage.

Test Plan:
- Reset/startup: rst high 2 cycles, im_ready tied 1, im_rdata=32'h00500093.
  - im_req rises the cycle after rst drops, with im_addr=0.
  - Next cycle: if_id_instr=32'h00500093, if_id_pc=0, valid=1.
  - Subsequent addresses are 4, 8, 12.
- Slow memory: im_ready low 3 cycles on addr 0x8.
  - im_addr holds 0x8 throughout.
  - if_id_valid=0 (NOP) during the wait.
  - Word captured with pc=0x8 on the ready cycle.
- Stall with skid: stall high 2 cycles while word at 0xC returns.
  - IF/ID holds the 0x8 instruction.
  - im_req=0 in S_FULL.
  - After stall drops: 0xC presented, then fetch resumes at 0x10.
- Flush during outstanding request: flush with redirect_pc=0x100 while 0x14 is pending, ready 2 cycles later.
  - 0x14 word discarded; IF/ID shows NOP, valid=0.
  - Next im_addr=0x100; if_id_pc=0x100 follows.
- Flush+stall simultaneous in S_FULL with redirect_pc=0x40:
  - IF/ID becomes NOP, valid=0; skid cleared.
  - Next request at 0x40; the buffered word never appears.
- Wrap and mid-op reset:
  - Redirect to 32'hFFFFFFFC: next fetch address is 0.
  - rst asserted during S_KILL: all outputs take reset values next cycle; fetch restarts at RESET_PC.
